// File: rtl/sequential_divider_pkg.sv
// rtl/sequential_divider_pkg.sv - shared state encoding and sizing helper for the divider
package sequential_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift, trial subtract, restore or keep
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] trial;

  // The extra bit absorbs the shifted-out MSB so divisors with MSB=1 work;
  // trial[WIDTH] set means the trial subtraction borrowed.
  assign r_sh    = {rem, quo[WIDTH-1]};
  assign trial   = r_sh - {1'b0, dvs};
  assign rem_nxt = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/flopenr.sv
// rtl/flopenr.sv - enabled register with asynchronous active-low reset
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - iterative radix-2 restoring unsigned divider, start/done handshake
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t          state;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic            accept;
  logic            dvs_zero;

  assign accept   = en && start && (state == IDLE || state == DONE);
  assign dvs_zero = (divisor == '0);

  flopenr #(.WIDTH(WIDTH)) u_dvs_reg (
    .clk   (clk),
    .reset (reset),
    .en    (accept && !dvs_zero),
    .d     (divisor),
    .q     (dvs_q)
  );

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (remainder),
    .quo     (quotient),
    .dvs     (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE, DONE: begin
          if (start && !dvs_zero) begin
            quotient    <= dividend;
            remainder   <= '0;
            count       <= CW'(WIDTH);
            div_by_zero <= 1'b0;
            state       <= RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
          end else if (start) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            // results and div_by_zero deliberately hold after done drops
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          quotient  <= quo_nxt;
          remainder <= rem_nxt;
          count     <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// tb/tb_sequential_divider.sv - directed and random checks of sequential_divider at WIDTH 8 and 32
module tb_sequential_divider;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b1;
  logic start8 = 1'b0, start32 = 1'b0;
  logic [7:0]  n8 = '0, d8 = '0;
  logic [31:0] n32 = '0, d32 = '0;
  logic [7:0]  q8, r8;
  logic [31:0] q32, r32;
  logic busy8, done8, dz8, busy32, done32, dz32;

  always #5 clk = ~clk;

  sequential_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .start(start8), .dividend(n8), .divisor(d8),
    .quotient(q8), .remainder(r8), .busy(busy8), .done(done8), .div_by_zero(dz8)
  );

  sequential_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .en(en), .start(start32), .dividend(n32), .divisor(d32),
    .quotient(q32), .remainder(r32), .busy(busy32), .done(done32), .div_by_zero(dz32)
  );

  logic [31:0] o_q [2], o_r [2], i_n [2], i_d [2];
  logic        o_busy [2], o_done [2], o_dz [2], i_start [2];
  assign o_q[0] = {24'b0, q8};   assign o_q[1] = q32;
  assign o_r[0] = {24'b0, r8};   assign o_r[1] = r32;
  assign o_busy[0] = busy8;      assign o_busy[1] = busy32;
  assign o_done[0] = done8;      assign o_done[1] = done32;
  assign o_dz[0] = dz8;          assign o_dz[1] = dz32;
  assign i_start[0] = start8;    assign i_start[1] = start32;
  assign i_n[0] = {24'b0, n8};   assign i_n[1] = n32;
  assign i_d[0] = {24'b0, d8};   assign i_d[1] = d32;

  int n_pass = 0;
  int n_total = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a division is "cycles of work left", results come from / and %.
  int          wd [2] = '{8, 32};
  logic [31:0] mask [2] = '{32'hFF, 32'hFFFF_FFFF};
  int          m_left [2] = '{0, 0};
  bit          m_done [2] = '{0, 0};
  bit          m_valid [2] = '{1, 1};
  bit          m_dz [2] = '{0, 0};
  logic [31:0] m_q [2] = '{0, 0}, m_r [2] = '{0, 0}, m_n [2] = '{0, 0}, m_d [2] = '{1, 1};

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_left[i] <= 0; m_done[i] <= 0; m_valid[i] <= 1;
        m_q[i] <= '0; m_r[i] <= '0; m_dz[i] <= 0;
      end else if (en) begin
        if (m_left[i] > 0) begin
          m_left[i] <= m_left[i] - 1;
          if (m_left[i] == 1) begin
            m_done[i] <= 1; m_valid[i] <= 1;
            m_q[i] <= m_n[i] / m_d[i]; m_r[i] <= m_n[i] % m_d[i];
          end
        end else if (i_start[i]) begin
          if (i_d[i] != 0) begin
            m_left[i] <= wd[i]; m_done[i] <= 0; m_valid[i] <= 0; m_dz[i] <= 0;
            m_n[i] <= i_n[i]; m_d[i] <= i_d[i];
          end else begin
            m_done[i] <= 1; m_valid[i] <= 1; m_dz[i] <= 1;
            m_q[i] <= mask[i]; m_r[i] <= i_n[i];
          end
        end else begin
          m_done[i] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy_w%0d", wd[i]), {31'b0, o_busy[i]}, {31'b0, m_left[i] > 0});
        chk($sformatf("done_w%0d", wd[i]), {31'b0, o_done[i]}, {31'b0, m_done[i]});
        if (m_valid[i]) begin
          chk($sformatf("quot_w%0d", wd[i]), o_q[i], m_q[i]);
          chk($sformatf("rem_w%0d", wd[i]), o_r[i], m_r[i]);
          chk($sformatf("dz_w%0d", wd[i]), {31'b0, o_dz[i]}, {31'b0, m_dz[i]});
        end
      end
    end
  end

  task automatic step(inout int cnt);
    @(posedge clk); #1; cnt++;
  endtask

  // Called at #1 after an edge; the request is accepted on the following edge.
  task automatic issue(input int sel, input logic [31:0] n, input logic [31:0] d);
    if (sel == 0) begin start8 = 1; n8 = n[7:0]; d8 = d[7:0]; end
    else begin start32 = 1; n32 = n; d32 = d; end
    @(posedge clk); #1;
    start8 = 0; start32 = 0;
  endtask

  task automatic wait_done(input int sel, input int lat0, output int lat);
    lat = lat0;
    while (o_done[sel] !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 200) chk("done_timeout", 32'(lat), 32'(wd[sel]));
  endtask

  int lat;
  logic [31:0] rn, rd;
  logic [63:0] prod;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", {24'b0, q8}, 32'd0);
    chk("reset_busy_done_dz", {29'b0, busy8, done8, dz8}, 32'd0);
    reset = 1; chk_on = 1;
    @(posedge clk); #1;

    issue(0, 100, 7);
    wait_done(0, 0, lat);
    chk("lat_100_7", 32'(lat), 32'd8);
    chk("q_100_7", {24'b0, q8}, 32'd14);
    chk("r_100_7", {24'b0, r8}, 32'd2);
    chk("dz_100_7", {31'b0, dz8}, 32'd0);
    @(posedge clk); #1;

    issue(0, 255, 1);
    wait_done(0, 0, lat);
    chk("q_255_1", {24'b0, q8}, 32'd255);
    chk("r_255_1", {24'b0, r8}, 32'd0);
    issue(0, 200, 255);
    chk("b2b_done_low", {31'b0, done8}, 32'd0);
    wait_done(0, 0, lat);
    chk("lat_b2b", 32'(lat), 32'd8);
    chk("q_200_255", {24'b0, q8}, 32'd0);
    chk("r_200_255", {24'b0, r8}, 32'd200);
    @(posedge clk); #1;

    issue(0, 5, 0);
    wait_done(0, 0, lat);
    chk("lat_div0", 32'(lat), 32'd0);
    chk("q_div0", {24'b0, q8}, 32'hFF);
    chk("r_div0", {24'b0, r8}, 32'd5);
    chk("dz_div0", {31'b0, dz8}, 32'd1);
    repeat (2) @(posedge clk); #1;
    chk("dz_held", {31'b0, dz8}, 32'd1);

    issue(0, 100, 7);
    lat = 0;
    repeat (3) step(lat);
    en = 0;
    repeat (3) step(lat);
    en = 1;
    start8 = 1; n8 = 8'd1; d8 = 8'd1;
    step(lat);
    start8 = 0;
    wait_done(0, lat, lat);
    chk("lat_stall", 32'(lat), 32'd11);
    chk("q_stall", {24'b0, q8}, 32'd14);
    chk("r_stall", {24'b0, r8}, 32'd2);
    @(posedge clk); #1;

    issue(1, 32'hFFFF_FFFF, 32'h8000_0000);
    wait_done(1, 0, lat);
    chk("lat_w32", 32'(lat), 32'd32);
    chk("q_w32_msb", q32, 32'd1);
    chk("r_w32_msb", r32, 32'h7FFF_FFFF);

    for (int k = 0; k < 1000; k++) begin
      rn = $urandom;
      rd = $urandom >> $urandom_range(0, 31);
      if (rd == 0) rd = 32'd1;
      issue(1, rn, rd);
      wait_done(1, 0, lat);
      prod = {32'b0, q32} * {32'b0, rd} + {32'b0, r32};
      chk("rand_identity", prod[31:0] ^ rn | {31'b0, |prod[63:32]}, 32'd0);
      chk("rand_rem_lt_div", {31'b0, r32 < rd}, 32'd1);
    end
    @(posedge clk); #1;

    issue(0, 100, 7);
    lat = 0;
    repeat (3) step(lat);
    #2 reset = 0;
    #1;
    chk("async_rst_q", {24'b0, q8}, 32'd0);
    chk("async_rst_r", {24'b0, r8}, 32'd0);
    chk("async_rst_flags", {29'b0, busy8, done8, dz8}, 32'd0);
    @(posedge clk); #1;
    reset = 1;
    issue(0, 100, 7);
    wait_done(0, 0, lat);
    chk("lat_after_rst", 32'(lat), 32'd8);
    chk("q_after_rst", {24'b0, q8}, 32'd14);
    chk("r_after_rst", {24'b0, r8}, 32'd2);
    @(posedge clk); #1;

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
